// File: rtl/quad_decoder_counter_pkg.sv
// Shared constants for the quadrature decoder.
//   DIR_UP / DIR_DN : values of the dir output
//   PH_xx           : 2-bit {A,B} phase codes
//   ev_t            : decoded event per clock (none / up / down / illegal)
package quad_decoder_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_UP   = 2'd1,
        EV_DN   = 2'd2,
        EV_ILL  = 2'd3
    } ev_t;

endpackage

// File: rtl/quad_decoder_counter_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
//   clk    : destination clock
//   resetn : asynchronous active-low reset, clears every stage to 0
//   d      : asynchronous input
//   q      : d delayed STAGES clocks
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sr <= '0;
        else         sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature (A/B) decoder driving a loadable up/down position counter.
//   clk, resetn : system clock, asynchronous active-low reset
//   en          : count enable (decode keeps tracking when 0)
//   a_in, b_in  : asynchronous quadrature phases
//   load        : synchronous load of data_in into q (beats a step)
//   data_in     : load value
//   clr_err     : clears the sticky err flag
//   q           : position count
//   dir         : direction of the last valid step (1 = up)
//   step        : one-cycle pulse per counted step
//   err         : sticky illegal-transition flag
module quad_decoder_counter
    import quad_decoder_counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             step,
    output logic             err
);

    logic       a_s, b_s;
    logic [1:0] cur_ab, prev_ab;
    ev_t        ev;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk(clk), .resetn(resetn), .d(a_in), .q(a_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk(clk), .resetn(resetn), .d(b_in), .q(b_s)
    );

    assign cur_ab = {a_s, b_s};

    // A leading B counts up; a simultaneous change of both phases
    // cannot be attributed to a direction and is flagged.
    always_comb begin
        ev = EV_NONE;
        case ({prev_ab, cur_ab})
            {PH_00, PH_10}, {PH_10, PH_11},
            {PH_11, PH_01}, {PH_01, PH_00}: ev = EV_UP;
            {PH_00, PH_01}, {PH_01, PH_11},
            {PH_11, PH_10}, {PH_10, PH_00}: ev = EV_DN;
            {PH_00, PH_11}, {PH_11, PH_00},
            {PH_10, PH_01}, {PH_01, PH_10}: ev = EV_ILL;
            default:                        ev = EV_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_ab <= PH_00;
            q       <= '0;
            dir     <= DIR_UP;
            step    <= 1'b0;
            err     <= 1'b0;
        end else begin
            prev_ab <= cur_ab;
            step    <= 1'b0;

            // Direction tracks every valid step, even while loading or disabled.
            if (ev == EV_UP)      dir <= DIR_UP;
            else if (ev == EV_DN) dir <= DIR_DN;

            if (load) begin
                q <= data_in;
            end else if (en && ev == EV_UP) begin
                q    <= q + 1'b1;
                step <= 1'b1;
            end else if (en && ev == EV_DN) begin
                q    <= q - 1'b1;
                step <= 1'b1;
            end

            // A new error in the same cycle as clr_err must not be lost.
            if (ev == EV_ILL) err <= 1'b1;
            else if (clr_err) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed bench for quad_decoder_counter (WIDTH=4, SYNC_STAGES=2).
// Inputs change 2 time units after a rising edge; outputs are sampled there too.
module tb_quad_decoder_counter;

    logic       clk = 1'b0;
    logic       resetn, en, a_in, b_in, load, clr_err;
    logic [3:0] data_in, q;
    logic       dir, step, err;
    int         total = 0;
    int         bad = 0;
    int         steps;

    quad_decoder_counter #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .en(en), .a_in(a_in), .b_in(b_in),
        .load(load), .data_in(data_in), .clr_err(clr_err),
        .q(q), .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive A/B and hold for n clocks, counting step pulses seen.
    task automatic apply(input logic [1:0] ab, input int n, output int cnt);
        a_in = ab[1];
        b_in = ab[0];
        cnt  = 0;
        repeat (n) begin
            @(posedge clk);
            #2;
            if (step) cnt++;
        end
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; a_in = 1'b0; b_in = 1'b0;
        load = 1'b0; data_in = 4'h0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_q",    32'(q),    32'h0);
        chk("rst_dir",  32'(dir),  32'h1);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_err",  32'(err),  32'h0);
        resetn = 1'b1;
        en     = 1'b1;

        // 1: four up steps
        apply(2'b10, 4, steps); chk("t1_q1", 32'(q), 32'h1); chk("t1_s1", 32'(steps), 32'h1);
        apply(2'b11, 4, steps); chk("t1_q2", 32'(q), 32'h2); chk("t1_s2", 32'(steps), 32'h1);
        apply(2'b01, 4, steps); chk("t1_q3", 32'(q), 32'h3); chk("t1_s3", 32'(steps), 32'h1);
        apply(2'b00, 4, steps); chk("t1_q4", 32'(q), 32'h4); chk("t1_s4", 32'(steps), 32'h1);
        chk("t1_dir", 32'(dir), 32'h1);
        chk("t1_err", 32'(err), 32'h0);

        // 2: four down steps, wrap below zero, load, wrap above max
        apply(2'b01, 4, steps); chk("t2_q3", 32'(q), 32'h3);
        apply(2'b11, 4, steps); chk("t2_q2", 32'(q), 32'h2);
        apply(2'b10, 4, steps); chk("t2_q1", 32'(q), 32'h1);
        apply(2'b00, 4, steps); chk("t2_q0", 32'(q), 32'h0); chk("t2_dir", 32'(dir), 32'h0);
        apply(2'b01, 4, steps); chk("t2_wrapdn", 32'(q), 32'hF); chk("t2_sdn", 32'(steps), 32'h1);
        load = 1'b1; data_in = 4'hE;
        @(posedge clk); #2;
        load = 1'b0;
        chk("t2_load", 32'(q), 32'hE);
        apply(2'b00, 4, steps); chk("t2_upF", 32'(q), 32'hF); chk("t2_dirup", 32'(dir), 32'h1);
        apply(2'b10, 4, steps); chk("t2_wrapup", 32'(q), 32'h0);

        // 3: load coincides with an up step (preceded by a down step so dir moves)
        apply(2'b00, 4, steps); chk("t3_pre", 32'(q), 32'hF); chk("t3_predir", 32'(dir), 32'h0);
        a_in = 1'b1; b_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 load = 1'b1; data_in = 4'h5;
        @(posedge clk); #2;
        load = 1'b0;
        chk("t3_q", 32'(q), 32'h5);
        chk("t3_step", 32'(step), 32'h0);
        chk("t3_dir", 32'(dir), 32'h1);
        apply(2'b10, 2, steps); chk("t3_nostep", 32'(steps), 32'h0);
        apply(2'b11, 4, steps); chk("t3_next", 32'(q), 32'h6);

        // 4: disabled counting keeps tracking without counting
        en = 1'b0;
        apply(2'b01, 4, steps); chk("t4_s1", 32'(steps), 32'h0);
        apply(2'b00, 4, steps); chk("t4_s2", 32'(steps), 32'h0);
        apply(2'b10, 4, steps); chk("t4_s3", 32'(steps), 32'h0);
        apply(2'b11, 4, steps); chk("t4_s4", 32'(steps), 32'h0);
        chk("t4_q", 32'(q), 32'h6);
        chk("t4_dir", 32'(dir), 32'h1);
        en = 1'b1;
        apply(2'b01, 4, steps); chk("t4_resume", 32'(q), 32'h7); chk("t4_rs", 32'(steps), 32'h1);

        // 5: illegal transitions and err clearing
        apply(2'b10, 4, steps);
        chk("t5_err", 32'(err), 32'h1);
        chk("t5_q", 32'(q), 32'h7);
        chk("t5_dir", 32'(dir), 32'h1);
        chk("t5_step", 32'(steps), 32'h0);
        a_in = 1'b0; b_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk); #2;
        clr_err = 1'b0;
        chk("t5_setwins", 32'(err), 32'h1);
        @(posedge clk); #2;
        clr_err = 1'b1;
        @(posedge clk); #2;
        clr_err = 1'b0;
        chk("t5_clr", 32'(err), 32'h0);
        chk("t5_q2", 32'(q), 32'h7);

        // 6: asynchronous reset mid-operation
        apply(2'b11, 4, steps); chk("t6_q", 32'(q), 32'h6); chk("t6_dir0", 32'(dir), 32'h0);
        apply(2'b00, 4, steps); chk("t6_err1", 32'(err), 32'h1);
        a_in = 1'b1; b_in = 1'b1;
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("t6_rq",    32'(q),    32'h0);
        chk("t6_rdir",  32'(dir),  32'h1);
        chk("t6_rstep", 32'(step), 32'h0);
        chk("t6_rerr",  32'(err),  32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("t6_post_err", 32'(err), 32'h1);
        chk("t6_post_q",   32'(q),   32'h0);
        chk("t6_post_dir", 32'(dir), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
